// File: rtl/nn_axis_pkg.sv
// Shared constants for the NN classifier stream drivers: packet geometry,
// result field position, stream width and FSM state encoding.
package nn_axis_pkg;

    localparam int DATA_WIDTH  = 64;

    localparam int N_IN_WORDS  = 9;
    localparam int N_WB_WORDS  = 10;
    localparam int N_RES_WORDS = 4;
    localparam int N_PKT_WORDS = N_IN_WORDS + N_WB_WORDS;

    localparam int PKT_AW      = 5;
    localparam int RES_AW      = 2;

    // The classifier returns its 16-bit result in the top bits of each word.
    localparam int RES_WIDTH   = 16;
    localparam int RES_LSB     = 48;
    localparam int RES_MSB     = RES_LSB + RES_WIDTH - 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_RECV = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        SEND = ST_SEND,
        RECV = ST_RECV,
        DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/nn_pkt_buffer.sv
// Request packet register file: one synchronous write port, one
// combinational read port. Writes to addresses past DEPTH-1 are dropped.
module nn_pkt_buffer
    import nn_axis_pkg::*;
#(
    parameter int DEPTH = N_PKT_WORDS,
    parameter int WIDTH = DATA_WIDTH,
    parameter int AW    = PKT_AW
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] din,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Store one packet word per accepted write.
    // NOTE: the array has no reset on purpose; its contents are always
    // written by the host before use and must survive a driver reset.
    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (we && (waddr < AW'(DEPTH))) begin
            mem[waddr] <= din;
        end
    end

    assign dout = (raddr < AW'(DEPTH)) ? mem[raddr] : '0;

endmodule

// File: rtl/axis_nn_classification_driver.sv
// Host-side driver for the streaming NN classifier: sends the stored
// 19-word request packet as an AXI-Stream master, then collects the
// 4-word result stream and keeps the 16-bit result fields readable.
module axis_nn_classification_driver #(
    parameter int N_IN_WORDS     = nn_axis_pkg::N_IN_WORDS,
    parameter int N_WB_WORDS     = nn_axis_pkg::N_WB_WORDS,
    parameter int N_RES_WORDS    = nn_axis_pkg::N_RES_WORDS,
    parameter int DATA_WIDTH     = nn_axis_pkg::DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                              aclk,
    input  logic                              areset,
    input  logic                              start,
    output logic                              ready,
    output logic                              done,
    output logic                              err_tlast,
    output logic                              timeout,
    input  logic                              pkt_we,
    input  logic [nn_axis_pkg::PKT_AW-1:0]    pkt_addr,
    input  logic [DATA_WIDTH-1:0]             pkt_din,
    input  logic [nn_axis_pkg::RES_AW-1:0]    res_addr,
    output logic [nn_axis_pkg::RES_WIDTH-1:0] res_dout,
    input  logic                              m_axis_tready,
    output logic [DATA_WIDTH-1:0]             m_axis_tdata,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    output logic                              s_axis_tready,
    input  logic [DATA_WIDTH-1:0]             s_axis_tdata,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast
);

    import nn_axis_pkg::*;

    localparam int N_PKT = N_IN_WORDS + N_WB_WORDS;
    localparam int TW    = $clog2(TIMEOUT_CYCLES);

    localparam logic [PKT_AW-1:0] LAST_PKT  = PKT_AW'(N_PKT - 1);
    localparam logic [PKT_AW-1:0] LAST_RES  = PKT_AW'(N_RES_WORDS - 1);
    localparam logic [TW-1:0]     TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);

    state_t              state, state_d;
    logic [PKT_AW-1:0]   idx, idx_d;
    logic [TW-1:0]       timer, timer_d;
    logic                err_q, err_d;
    logic                to_q, to_d;
    logic                buf_we;
    logic                res_we;
    logic                end_beat;
    logic [RES_WIDTH-1:0] res_buf [N_RES_WORDS];

    // Only the result field of each returned word carries information.
    logic unused_tdata;
    assign unused_tdata = ^s_axis_tdata[RES_LSB-1:0];

    // The packet buffer read port follows idx, so tdata holds while stalled.
    nn_pkt_buffer #(
        .DEPTH (N_PKT),
        .WIDTH (DATA_WIDTH),
        .AW    (PKT_AW)
    ) u_pkt_buf (
        .clk   (aclk),
        .we    (buf_we),
        .waddr (pkt_addr),
        .din   (pkt_din),
        .raddr (idx),
        .dout  (m_axis_tdata)
    );

    // A result beat that closes the transaction: explicit tlast or 4th word.
    assign end_beat = s_axis_tvalid && (s_axis_tlast || (idx == LAST_RES));

    // FSM state, word index, RECV timer and sticky status flags.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= IDLE;
            idx   <= '0;
            timer <= '0;
            err_q <= 1'b0;
            to_q  <= 1'b0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
            timer <= timer_d;
            err_q <= err_d;
            to_q  <= to_d;
        end
    end

    // Next-state logic and handshake outputs.
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d       = state;
        idx_d         = idx;
        timer_d       = timer;
        err_d         = err_q;
        to_d          = to_q;
        buf_we        = 1'b0;
        res_we        = 1'b0;
        ready         = 1'b0;
        done          = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = 1'b0;

        case (state)
            IDLE: begin
                ready  = 1'b1;
                buf_we = pkt_we;
                if (start) begin
                    state_d = SEND;
                    idx_d   = '0;
                    err_d   = 1'b0;
                    to_d    = 1'b0;
                end
            end

            SEND: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = (idx == LAST_PKT);
                if (m_axis_tready) begin
                    if (idx == LAST_PKT) begin
                        state_d = RECV;
                        idx_d   = '0;
                        timer_d = '0;
                    end else begin
                        idx_d = idx + 1'b1;
                    end
                end
            end

            RECV: begin
                s_axis_tready = 1'b1;
                timer_d       = timer + 1'b1;
                if (s_axis_tvalid) begin
                    res_we = 1'b1;
                    if (!end_beat) begin
                        idx_d = idx + 1'b1;
                    end
                end
                if (end_beat) begin
                    // Early tlast, or a 4th word without tlast, is a framing error.
                    err_d   = err_q | (s_axis_tlast != (idx == LAST_RES));
                    state_d = DONE;
                end else if (timer == TIMER_MAX) begin
                    to_d    = 1'b1;
                    state_d = DONE;
                end
            end

            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // Result buffer: cleared by reset, one field captured per accepted beat.
    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int i = 0; i < N_RES_WORDS; i++) begin
                res_buf[i] <= '0;
            end
        end else if (res_we) begin
            res_buf[idx[RES_AW-1:0]] <= s_axis_tdata[RES_MSB:RES_LSB];
        end
    end

    assign res_dout  = res_buf[res_addr];
    assign err_tlast = err_q;
    assign timeout   = to_q;

endmodule

// File: doc/axis_nn_classification_driver.md
Name: axis_nn_classification_driver

Overview:
- Host-side counterpart of the streaming NN classifier wrapper.
- Holds one 19-word request packet: words 0-8 are input, words 9-18 are weight/bias.
- On start, transmits the packet as an AXI-Stream master, then receives the 4-word result stream as an AXI-Stream slave.
- Extracts the 16-bit result field of each word into a readable result buffer. Used as on-chip test driver and as a DMA stand-in in integration.

Parameters:
- N_IN_WORDS, 9, input words per packet
- N_WB_WORDS, 10, weight/bias words per packet
- N_RES_WORDS, 4, result words expected per packet
- DATA_WIDTH, 64, stream word width
- TIMEOUT_CYCLES, 65535, maximum cycles in RECV before abort

Ports:
- aclk  in  1  clock
- areset  in  1  reset, synchronous, active-high
- start  in  1  begin transaction; honoured only while ready=1
- ready  out  1  idle and accepting start/packet writes
- done  out  1  one-cycle pulse when a transaction ends (normal or abort)
- err_tlast  out  1  sticky: tlast missing or early on the result stream
- timeout  out  1  sticky: result stream did not complete in time
- pkt_we  in  1  packet buffer write enable
- pkt_addr  in  5  packet buffer word address, 0..18
- pkt_din  in  64  packet buffer write data
- res_addr  in  2  result buffer read address
- res_dout  out  16  result buffer read data (combinational from res_addr)
- m_axis_tready  in  1  downstream ready
- m_axis_tdata  out  64  request word
- m_axis_tvalid  out  1  request valid
- m_axis_tlast  out  1  asserted on word 18
- s_axis_tready  out  1  result ready
- s_axis_tdata  in  64  result word; payload in bits [63:48]
- s_axis_tvalid  in  1  result valid
- s_axis_tlast  in  1  result last

Behaviour:
- Reset (areset=1 at a rising edge): state=IDLE, idx=0, timer=0.
- Output reset values: ready=1, done=0, err_tlast=0, timeout=0, m_axis_tvalid=0, m_axis_tlast=0, s_axis_tready=0.
- Reset clears the result buffer to 0. The packet buffer is not reset.
- Reset mid-transfer aborts immediately. No done pulse is produced.
- States: IDLE, SEND, RECV, DONE.
- IDLE:
  - ready=1.
  - pkt_we writes pkt_buf[pkt_addr]. Addresses >18 are ignored.
  - On start: go to SEND, idx=0, clear err_tlast and timeout.
  - If pkt_we and start occur in the same cycle, the write lands first and is included in the packet.
- SEND:
  - m_axis_tvalid=1, m_axis_tdata=pkt_buf[idx], m_axis_tlast=(idx==18).
  - On tvalid&&tready: if idx==18, go to RECV with idx=0; otherwise idx+1.
  - While tready=0: tdata, tvalid and tlast are held stable. tvalid never drops before the handshake.
- RECV:
  - s_axis_tready=1. The timer increments every cycle.
  - On a beat: res_buf[idx]=s_axis_tdata[63:48].
  - tlast=1 with idx<3: set err_tlast, go to DONE.
  - idx==3: if tlast=0, set err_tlast. Go to DONE in either case.
  - Otherwise idx+1.
  - Timer reaching TIMEOUT_CYCLES-1 with no completing beat: set timeout, go to DONE. A beat in that same cycle takes priority and completes normally.
- DONE: done=1 for exactly one cycle, then IDLE.
- ready=0 in SEND, RECV and DONE. start and pkt_we are ignored in those states.
- Result buffer is readable in every state and holds the last completed or partial results until overwritten.
- Latency with no stalls: start at cycle 0, first m beat at cycle 1, last m beat at cycle 19, RECV from cycle 20, done one cycle after the 4th result beat.

Decomposition:
- Shared package nn_axis_pkg:
  - packet word counts (9, 10, 4)
  - result field position [63:48]
  - state encoding localparams
  - DATA_WIDTH
- Natural sub-module: nn_pkt_buffer, a 19x64 register file with write port and combinational read port, reused by other driver blocks.
- Result buffer and FSM stay inline.

Test Plan:
- Load words 0..18 = 64'h1000+i, start, m_axis_tready=1, return 4 results with tdata[63:48]=16'hA000+i and tlast on the 4th. Required: 19 m beats in order with tlast only on 0x1012; res_dout(0..3)=A000..A003; done pulses once; err_tlast=0, timeout=0.
- Same load, but m_axis_tready toggles 1,0,0,1… and s_axis_tvalid is bursty. Required: identical word sequence, with tdata/tlast stable across every stall.
- Results with tlast on the 2nd word. Required: err_tlast=1, done after the 2nd beat, res_buf[2..3] unchanged.
- 4 results with no tlast. Required: err_tlast=1, done after the 4th beat.
- TIMEOUT_CYCLES=16 and no results sent. Required: timeout=1 and done 16 cycles after entering RECV; next start clears timeout.
- areset asserted during SEND word 7. Required: next cycle tvalid=0, ready=1, no done. Restart resends from word 0 with the preserved packet.
